// File: rtl/md5_block_builder.sv
`default_nettype none
// ============================================================================
// Module   : md5_block_builder
// Brief    : Loads a secret key once, then streams one padded 512-bit MD5
//            block per accepted handshake:
//            key || ASCII decimal index || 0x80 || zeros || 64-bit bit length.
//            The index is a BCD counter that grows its digit count on
//            all-9s carry out.
// Config   : MD5_BLOCK_BUILDER_START_AT_ONE_EN - when defined the first index
//            is 1, otherwise the first index is 0.
// Revision : 1.0 - initial release
// ============================================================================
module md5_block_builder #(
  parameter int BLOCK_WIDTH   = 512,
  parameter int KEY_MAX_BYTES = 16,
  parameter int MAX_DIGITS    = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      key_ready,
  input  logic                      key_valid,
  input  logic [7:0]                key_data,
  input  logic                      key_last,
  input  logic                      halt,
  input  logic                      md5_block_ready,
  output logic                      md5_block_valid,
  output logic [BLOCK_WIDTH-1:0]    md5_block_data,
  output logic [4*MAX_DIGITS-1:0]   block_index_bcd,
  output logic                      overflow
);

  localparam int KLW = $clog2(KEY_MAX_BYTES + 1);
  localparam int NDW = $clog2(MAX_DIGITS + 1);

`ifdef MD5_BLOCK_BUILDER_START_AT_ONE_EN
  localparam logic [3:0] START_DIGIT = 4'd1;
`else
  localparam logic [3:0] START_DIGIT = 4'd0;
`endif

  // The block layout is hard-wired to a single 512-bit MD5 block; the message
  // (key + digits + 0x80) must leave room for the 8-byte length field.
  generate
    if (BLOCK_WIDTH != 512) begin : g_bad_block_width
      $error("md5_block_builder: BLOCK_WIDTH must be 512");
    end
    if (KEY_MAX_BYTES + MAX_DIGITS > 55) begin : g_bad_msg_len
      $error("md5_block_builder: KEY_MAX_BYTES + MAX_DIGITS must be <= 55");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_LOAD_KEY = 2'd0,
    S_GEN      = 2'd1,
    S_DONE     = 2'd2
  } state_e;

  state_e                               state_q;
  logic [KEY_MAX_BYTES-1:0][7:0]        key_q,  key_d;
  logic [KLW-1:0]                       key_len_q, key_len_d;
  logic [MAX_DIGITS-1:0][3:0]           dig_q, dig_inc, dig_sel;
  logic [NDW-1:0]                       ndig_q, ndig_inc, ndig_sel;
  logic                                 key_ready_q;
  logic                                 valid_q;
  logic                                 ovf_q;
  logic [BLOCK_WIDTH-1:0]               data_q;
  logic [511:0]                         block_d;
  logic                                 key_hs;
  logic                                 all_nine;
  logic                                 at_max;
  logic                                 carry;

  // Assemble the padded block: key bytes, MSD-first ASCII digits, 0x80
  // terminator, zero fill, then the little-endian bit length in bytes 56..63.
  function automatic logic [511:0] build_block(
    input logic [KEY_MAX_BYTES-1:0][7:0] key,
    input int                            klen,
    input logic [MAX_DIGITS-1:0][3:0]    dig,
    input int                            nd
  );
    logic [55:0][7:0] msg;
    logic [7:0]       b;
    for (int p = 0; p < 56; p++) begin
      b = 8'h00;
      for (int i = 0; i < KEY_MAX_BYTES; i++) begin
        if (i == p && i < klen) b = key[i];
      end
      for (int k = 0; k < MAX_DIGITS; k++) begin
        if (k < nd && p == klen + nd - 1 - k) b = {4'h3, dig[k]};
      end
      if (p == klen + nd) b = 8'h80;
      msg[p] = b;
    end
    return {55'd0, 6'(klen + nd), 3'b000, msg};
  endfunction

  // Key capture: store the handshaked byte at key_len, saturating at the max.
  always_comb begin
    key_hs    = (state_q == S_LOAD_KEY) && key_valid && key_ready_q;
    key_d     = key_q;
    key_len_d = key_len_q;
    if (key_hs && int'(key_len_q) < KEY_MAX_BYTES) begin
      for (int i = 0; i < KEY_MAX_BYTES; i++) begin
        if (int'(key_len_q) == i) key_d[i] = key_data;
      end
      key_len_d = key_len_q + KLW'(1);
    end
  end

  // BCD increment; digit count grows when every live digit was 9.
  always_comb begin
    all_nine = 1'b1;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if (k < int'(ndig_q) && dig_q[k] != 4'd9) all_nine = 1'b0;
    end
    at_max  = all_nine && (int'(ndig_q) == MAX_DIGITS);
    dig_inc = dig_q;
    carry   = 1'b1;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if (carry) begin
        if (dig_inc[k] == 4'd9) begin
          dig_inc[k] = 4'd0;
        end else begin
          dig_inc[k] = dig_inc[k] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
    ndig_inc = all_nine ? ndig_q + NDW'(1) : ndig_q;
  end

  // One block builder serves both GEN entry (start index, key incl. the byte
  // arriving now) and subsequent accepts (incremented index).
  always_comb begin
    dig_sel  = (state_q == S_LOAD_KEY) ? dig_q  : dig_inc;
    ndig_sel = (state_q == S_LOAD_KEY) ? ndig_q : ndig_inc;
    block_d  = build_block(key_d, int'(key_len_d), dig_sel, int'(ndig_sel));
  end

  // Control FSM with registered outputs: LOAD_KEY -> GEN -> DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD_KEY;
      key_q       <= '0;
      key_len_q   <= '0;
      dig_q       <= (4*MAX_DIGITS)'(START_DIGIT);
      ndig_q      <= NDW'(1);
      key_ready_q <= 1'b1;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      key_q     <= key_d;
      key_len_q <= key_len_d;
      case (state_q)
        S_LOAD_KEY: begin
          if (key_hs && key_last) begin
            state_q     <= S_GEN;
            key_ready_q <= 1'b0;
            valid_q     <= 1'b1;
            data_q      <= block_d;
          end
        end
        S_GEN: begin
          if (halt) begin
            state_q <= S_DONE;
            valid_q <= 1'b0;
          end else if (valid_q && md5_block_ready) begin
            if (at_max) begin
              state_q <= S_DONE;
              ovf_q   <= 1'b1;
              valid_q <= 1'b0;
            end else begin
              dig_q  <= dig_inc;
              ndig_q <= ndig_inc;
              data_q <= block_d;
            end
          end
        end
        S_DONE: begin
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= S_LOAD_KEY;
        end
      endcase
    end
  end

  assign key_ready       = key_ready_q;
  assign md5_block_valid = valid_q;
  assign md5_block_data  = data_q;
  assign block_index_bcd = dig_q;
  assign overflow        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_md5_block_builder.sv
`default_nettype none
// ============================================================================
// Module   : tb_md5_block_builder
// Brief    : Directed self-checking bench. dut1 uses default parameters;
//            dut2 uses MAX_DIGITS=2 to reach index overflow quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md5_block_builder;

`ifdef MD5_BLOCK_BUILDER_START_AT_ONE_EN
  localparam int START = 1;
`else
  localparam int START = 0;
`endif

  logic         clk = 1'b0;
  logic         reset, key_valid, key_last, halt, rdy;
  logic [7:0]   key_data;
  logic         key_ready, vld, ovf;
  logic [511:0] data;
  logic [39:0]  bcd;

  logic         reset2, kv2, kl2, halt2, rdy2;
  logic [7:0]   kd2;
  logic         key_ready2, vld2, ovf2;
  logic [511:0] data2;
  logic [7:0]   bcd2;

  int checks = 0;
  int errors = 0;
  int exp_idx;
  logic [511:0] held_data;
  logic [39:0]  held_bcd;
  logic [39:0]  tmp_bcd;

  always #5 clk = ~clk;

  md5_block_builder dut1 (
    .clk(clk), .reset(reset), .key_ready(key_ready), .key_valid(key_valid),
    .key_data(key_data), .key_last(key_last), .halt(halt),
    .md5_block_ready(rdy), .md5_block_valid(vld), .md5_block_data(data),
    .block_index_bcd(bcd), .overflow(ovf)
  );

  md5_block_builder #(.MAX_DIGITS(2)) dut2 (
    .clk(clk), .reset(reset2), .key_ready(key_ready2), .key_valid(kv2),
    .key_data(kd2), .key_last(kl2), .halt(halt2),
    .md5_block_ready(rdy2), .md5_block_valid(vld2), .md5_block_data(data2),
    .block_index_bcd(bcd2), .overflow(ovf2)
  );

  // Reference block: key || decimal(idx) || 0x80 || 0 || LE bit length.
  function automatic logic [511:0] exp_block(input string key, input int idx);
    string s;
    logic [511:0] blk;
    int L;
    s   = {key, $sformatf("%0d", idx)};
    L   = s.len();
    blk = '0;
    for (int i = 0; i < L; i++) blk[8*i +: 8] = s[i];
    blk[8*L +: 8]  = 8'h80;
    blk[511:448]   = 64'(L * 8);
    return blk;
  endfunction

  function automatic logic [39:0] exp_bcd(input int idx);
    logic [39:0] r;
    int v;
    v = idx;
    for (int d = 0; d < 10; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_bcd(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic load_key(input int which, input string k, input bit halt_in_load);
    for (int i = 0; i < k.len(); i++) begin
      if (which == 0) begin
        key_valid = 1'b1;
        key_data  = k[i];
        key_last  = (i == k.len() - 1);
        halt      = halt_in_load && (i != k.len() - 1);
      end else begin
        kv2 = 1'b1;
        kd2 = k[i];
        kl2 = (i == k.len() - 1);
      end
      step();
    end
    key_valid = 1'b0; key_last = 1'b0; halt = 1'b0;
    kv2 = 1'b0; kl2 = 1'b0;
  endtask

  // dut1 advance with ready high, checking every presented block.
  task automatic advance_to(input int target);
    while (exp_idx < target) begin
      step();
      exp_idx++;
      chk_bit("adv_valid", vld, 1'b1);
      chk_blk("adv_data", data, exp_block("abcdef", exp_idx));
      chk_bcd("adv_bcd", bcd, exp_bcd(exp_idx));
    end
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_data = 8'h00; key_last = 1'b0;
    halt = 1'b0; rdy = 1'b0;
    reset2 = 1'b1; kv2 = 1'b0; kd2 = 8'h00; kl2 = 1'b0; halt2 = 1'b0; rdy2 = 1'b0;
    step(); step();

    // Reset state
    chk_bit("rst_key_ready", key_ready, 1'b1);
    chk_bit("rst_valid", vld, 1'b0);
    chk_blk("rst_data", data, '0);
    chk_bit("rst_overflow", ovf, 1'b0);
    reset = 1'b0; reset2 = 1'b0;

    // First block after key load, downstream not ready yet
    load_key(0, "abcdef", 1'b0);
    exp_idx = START;
    chk_bit("first_valid", vld, 1'b1);
    chk_bit("first_key_ready", key_ready, 1'b0);
    chk_blk("first_data", data, exp_block("abcdef", START));
    chk_bcd("first_bcd", bcd, exp_bcd(START));
    chk_byte("first_byte7", data[63:56], 8'h80);
    chk_byte("first_byte56", data[455:448], 8'h38);

    // One block per cycle while ready
    rdy = 1'b1;
    advance_to(3);

    // Backpressure on index 3
    rdy = 1'b0;
    held_data = data;
    held_bcd  = bcd;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_bit("bp_valid", vld, 1'b1);
      chk_blk("bp_data", data, held_data);
      chk_bcd("bp_bcd", bcd, held_bcd);
    end
    rdy = 1'b1;
    advance_to(4);

    // Rollover 9 -> 10
    advance_to(10);
    chk_byte("roll_byte8", data[71:64], 8'h80);
    chk_byte("roll_byte56", data[455:448], 8'h40);
    advance_to(11);

    // Reset mid-GEN
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_bit("midgen_rst_key_ready", key_ready, 1'b1);
    chk_bit("midgen_rst_valid", vld, 1'b0);
    chk_blk("midgen_rst_data", data, '0);

    // Reload with halt asserted during LOAD_KEY (ignored), ready already high
    load_key(0, "abcdef", 1'b1);
    exp_idx = START;
    chk_bit("reload_valid", vld, 1'b1);
    chk_blk("reload_data", data, exp_block("abcdef", START));
    advance_to(7);

    // halt together with the handshake of index 7
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk_bit("halt_valid", vld, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_bit("done_valid", vld, 1'b0);
      chk_bit("done_key_ready", key_ready, 1'b0);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_bit("done_rst_key_ready", key_ready, 1'b1);

    // dut2: MAX_DIGITS=2 overflow
    rdy2 = 1'b1;
    load_key(1, "x", 1'b0);
    exp_idx = START;
    chk_blk("d2_first", data2, exp_block("x", START));
    while (exp_idx < 99) begin
      step();
      exp_idx++;
      tmp_bcd = exp_bcd(exp_idx);
      chk_byte("d2_bcd", bcd2, tmp_bcd[7:0]);
      chk_bit("d2_valid", vld2, 1'b1);
    end
    chk_blk("d2_data99", data2, exp_block("x", 99));
    step();
    chk_bit("d2_ovf", ovf2, 1'b1);
    chk_bit("d2_ovf_valid", vld2, 1'b0);
    step(); step();
    chk_bit("d2_ovf_hold", ovf2, 1'b1);
    chk_bit("d2_ovf_hold_valid", vld2, 1'b0);
    reset2 = 1'b1;
    step();
    reset2 = 1'b0;
    chk_bit("d2_rst_ovf", ovf2, 1'b0);
    chk_bit("d2_rst_key_ready", key_ready2, 1'b1);

    // Over-long key saturates at 16 bytes; then reset mid-GEN
    rdy2 = 1'b0;
    load_key(1, "0123456789ABCDEFGH", 1'b0);
    chk_blk("d2_sat_key", data2, exp_block("0123456789ABCDEF", START));
    chk_bit("d2_sat_valid", vld2, 1'b1);
    step();
    reset2 = 1'b1;
    step();
    reset2 = 1'b0;
    chk_bit("d2_midgen_key_ready", key_ready2, 1'b1);
    chk_bit("d2_midgen_ovf", ovf2, 1'b0);
    chk_bit("d2_midgen_valid", vld2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
